apb_bridge_gen2: RTL and testbench

Parametrised AHB-Lite slave to APB4 master bridge, successor to the fixed 8-slave bridge in the peripheral subsystem. It decodes a configurable number of equally sized peripheral slots from a base address and honours APB PREADY wait states. PSLVERR, decode misses and a per-access timeout are all reported as a two-cycle AHB ERROR response. It also generates APB4 PSTRB from HSIZE/HADDR.

---
 rtl/apb_bridge_gen2.sv | 219 +++++++++++++++++++++
 tb/tb_apb_bridge_gen2.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_gen2.sv
`default_nettype none
// ============================================================================
// Module   : apb_bridge_gen2
// Brief    : AHB-Lite slave to APB4 master bridge with slot decode, PREADY
//            wait states, PSTRB generation and two-cycle AHB ERROR responses.
// Revision : 1.0 - initial release
// ============================================================================
module apb_bridge_gen2 #(
    parameter int                    NUM_SLAVES     = 8,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4001_0000,
    parameter int                    SLOT_BITS      = 12,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             hsel,
    input  logic [ADDR_WIDTH-1:0]            haddr,
    input  logic [1:0]                       htrans,
    input  logic                             hwrite,
    input  logic [2:0]                       hsize,
    input  logic [DATA_WIDTH-1:0]            hwdata,
    input  logic                             hready_in,
    output logic                             hreadyout,
    output logic                             hresp,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [3:0]                       pstrb,
    output logic                             penable,
    output logic [NUM_SLAVES-1:0]            psel,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    localparam int c_slot_w = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int c_cnt_w  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_cnt_w-1:0]    c_tmo_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_num_slots = ADDR_WIDTH'(NUM_SLAVES);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_wdata  = 3'd1;
    localparam logic [2:0] c_st_setup  = 3'd2;
    localparam logic [2:0] c_st_access = 3'd3;
    localparam logic [2:0] c_st_err1   = 3'd4;
    localparam logic [2:0] c_st_err2   = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [3:0]            r_pstrb;
    logic [c_slot_w-1:0]   r_slot;
    logic [c_cnt_w-1:0]    r_tcnt;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_launch;
    logic                  w_miss;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_slot_full;
    logic [3:0]            w_strb;
    logic [NUM_SLAVES-1:0] w_hit;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_in_access;
    logic                  w_ok_done;
    logic                  w_err_done;
    logic                  w_tmo;
    logic [2:0]            w_accept_tgt;
    logic                  w_apb_active;

    // NONSEQ and SEQ are the only transfer types that start an access
    assign w_req = hsel & hready_in & ((htrans == 2'b10) | (htrans == 2'b11));

    assign w_off       = haddr - BASE_ADDR;
    assign w_slot_full = w_off >> SLOT_BITS;
    assign w_miss      = (haddr < BASE_ADDR) | (w_slot_full >= c_num_slots);

    always_comb begin
        w_strb = 4'b0000;
        if (hwrite) begin
            case (hsize)
                3'd0:    w_strb = 4'b0001 << haddr[1:0];
                3'd1:    w_strb = 4'b0011 << haddr[1:0];
                default: w_strb = 4'b1111;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
            assign w_hit[gi] = (r_slot == c_slot_w'(gi));
        end
    endgenerate

    assign w_sel_ready = |(pready & w_hit);
    assign w_sel_err   = |(pslverr & w_hit);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_hit[i]) begin
                w_sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_in_access = (r_state == c_st_access);
    assign w_ok_done   = w_in_access & w_sel_ready & ~w_sel_err;
    assign w_err_done  = w_in_access & w_sel_ready & w_sel_err;
    // A PREADY arriving on the last counted cycle still wins over the timeout
    assign w_tmo       = w_in_access & ~w_sel_ready & (r_tcnt == c_tmo_last);

    assign w_accept = w_req & ((r_state == c_st_idle) | w_ok_done | (r_state == c_st_err2));
    assign w_launch = w_accept & ~w_miss;

    assign w_accept_tgt = w_miss ? c_st_err1 : (hwrite ? c_st_wdata : c_st_setup);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = w_accept_tgt;
                end
            end
            c_st_wdata: w_state_nxt = c_st_setup;
            c_st_setup: w_state_nxt = c_st_access;
            c_st_access: begin
                if (w_ok_done) begin
                    w_state_nxt = w_accept ? w_accept_tgt : c_st_idle;
                end else if (w_err_done | w_tmo) begin
                    w_state_nxt = c_st_err1;
                end
            end
            c_st_err1: w_state_nxt = c_st_err2;
            c_st_err2: w_state_nxt = w_accept ? w_accept_tgt : c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        hreadyout    = 1'b1;
        hresp        = 1'b0;
        penable      = 1'b0;
        w_apb_active = 1'b0;
        case (r_state)
            c_st_wdata: hreadyout = 1'b0;
            c_st_setup: begin
                hreadyout    = 1'b0;
                w_apb_active = 1'b1;
            end
            c_st_access: begin
                hreadyout    = w_ok_done;
                penable      = 1'b1;
                w_apb_active = 1'b1;
            end
            c_st_err1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            c_st_err2: hresp = 1'b1;
            default: ;
        endcase
    end

    assign psel   = w_hit & {NUM_SLAVES{w_apb_active}};
    assign hrdata = (w_ok_done & ~r_pwrite) ? w_sel_rdata : '0;

    // APB request fields are only reloaded by a decoded launch, so a miss
    // leaves the APB side untouched
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= 4'b0000;
            r_slot   <= '0;
            r_tcnt   <= '0;
        end else begin
            if (w_launch) begin
                r_paddr  <= haddr;
                r_pwrite <= hwrite;
                r_pstrb  <= w_strb;
                r_slot   <= w_slot_full[c_slot_w-1:0];
            end
            if (r_state == c_st_wdata) begin
                r_pwdata <= hwdata;
            end
            if (w_in_access) begin
                r_tcnt <= r_tcnt + c_cnt_w'(1);
            end else begin
                r_tcnt <= '0;
            end
        end
    end

    assign paddr  = r_paddr;
    assign pwrite = r_pwrite;
    assign pwdata = r_pwdata;
    assign pstrb  = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_bridge_gen2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_apb_bridge_gen2
// Brief    : Scoreboard bench for apb_bridge_gen2 with an APB slave responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_bridge_gen2;

    localparam int          NS   = 8;
    localparam int          TMO  = 16;
    localparam logic [31:0] BASE = 32'h4001_0000;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           hsel = 1'b0;
    logic [31:0]    haddr = '0;
    logic [1:0]     htrans = 2'b00;
    logic           hwrite = 1'b0;
    logic [2:0]     hsize = 3'd2;
    logic [31:0]    hwdata = '0;
    logic           hready_in;
    logic           hreadyout;
    logic           hresp;
    logic [31:0]    hrdata;
    logic [31:0]    paddr;
    logic           pwrite;
    logic [31:0]    pwdata;
    logic [3:0]     pstrb;
    logic           penable;
    logic [NS-1:0]  psel;
    logic [NS*32-1:0] prdata = '0;
    logic [NS-1:0]  pready = '0;
    logic [NS-1:0]  pslverr = '0;

    assign hready_in = hreadyout;

    apb_bridge_gen2 #(
        .NUM_SLAVES    (NS),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .BASE_ADDR     (BASE),
        .SLOT_BITS     (12),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hwdata   (hwdata),
        .hready_in(hready_in),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .hrdata   (hrdata),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .penable  (penable),
        .psel     (psel),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          waits;
    } ahb_exp_t;

    typedef struct {
        int          slot;
        logic [31:0] addr;
        bit          wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          k;
        bit          err;
        bit          to;
        logic [31:0] rdata;
    } apb_exp_t;

    ahb_exp_t    ahb_q[$];
    apb_exp_t    apb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_off = 1'b0;
    bit          hw_upd = 1'b0;
    logic [31:0] hw_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain address arithmetic and byte-lane counting
    function automatic bit ref_miss(input logic [31:0] a);
        if (a < BASE) return 1'b1;
        return ((a - BASE) / 32'd4096) >= 32'(NS);
    endfunction

    function automatic int ref_slot(input logic [31:0] a);
        return int'((a - BASE) / 32'd4096);
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] a, input bit wr, input int sz);
        int nbytes;
        int mask;
        if (!wr) return 4'b0000;
        nbytes = 1 << sz;
        mask   = ((1 << nbytes) - 1) << (a % 4);
        return 4'(mask);
    endfunction

    task automatic apply_hw();
        if (hw_upd) begin
            hwdata = hw_val;
            hw_upd = 1'b0;
        end
    endtask

    task automatic issue(input logic [31:0] a, input bit wr, input int sz, input logic [31:0] wd,
                         input int k, input bit err, input bit to, input logic [31:0] rd);
        ahb_exp_t e;
        apb_exp_t p;
        int       guard;
        int       lead;
        e.rdata = wr ? 32'h0 : rd;
        if (ref_miss(a)) begin
            e.err   = 1'b1;
            e.waits = 1;
        end else begin
            p.slot = ref_slot(a);  p.addr = a;  p.wr = wr;  p.strb = ref_strb(a, wr, sz);
            p.wdata = wd;  p.k = k;  p.err = err;  p.to = to;  p.rdata = rd;
            apb_q.push_back(p);
            lead = wr ? 2 : 1;
            if (to) begin
                e.err = 1'b1;  e.waits = lead + TMO + 1;
            end else if (err) begin
                e.err = 1'b1;  e.waits = lead + k + 2;
            end else begin
                e.err = 1'b0;  e.waits = lead + k;
            end
        end
        ahb_q.push_back(e);
        @(negedge clk);
        apply_hw();
        hsel   = 1'b1;
        haddr  = a;
        htrans = ($urandom % 2 == 0) ? 2'b10 : 2'b11;
        hwrite = wr;
        hsize  = 3'(sz);
        guard  = 0;
        #2;
        while (!hreadyout && guard < 200) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!hreadyout) begin
            vectors++;
            miscompares++;
            $display("FAIL addr_phase_stall: hreadyout got 0, expected 1 at %0t", $time);
        end
        hw_upd = 1'b1;
        hw_val = wr ? wd : $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            apply_hw();
            case ($urandom % 3)
                0:       begin hsel = 1'b0; htrans = 2'b10; end
                1:       begin hsel = 1'b1; htrans = 2'b00; end
                default: begin hsel = 1'b1; htrans = 2'b01; end
            endcase
            haddr  = BASE + 32'($urandom % NS) * 32'd4096;
            hwrite = 1'($urandom);
            hsize  = 3'd2;
        end
    endtask

    // AHB monitor: tracks data phases from the bus and pops on completion
    initial begin : ahb_mon
        bit       in_dp;
        int       waits;
        int       errw;
        ahb_exp_t e;
        in_dp = 1'b0;  waits = 0;  errw = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn || mon_off) begin
                in_dp = 1'b0;
                continue;
            end
            if (in_dp) begin
                if (!hreadyout) begin
                    waits++;
                    if (hresp) errw++;
                end else begin
                    if (ahb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL ahb_unexpected: completion with empty queue at %0t", $time);
                    end else begin
                        e = ahb_q.pop_front();
                        check("hresp", 32'(hresp), 32'(e.err));
                        check("wait_cycles", 32'(waits), 32'(e.waits));
                        check("err_first_cycle", 32'(errw), e.err ? 32'd1 : 32'd0);
                        if (!e.err) check("hrdata", hrdata, e.rdata);
                    end
                    in_dp = 1'b0;
                end
            end else begin
                check("idle_hreadyout", 32'(hreadyout), 32'd1);
                check("idle_hresp", 32'(hresp), 32'd0);
            end
            if (hsel && htrans[1] && hreadyout) begin
                in_dp = 1'b1;
                waits = 0;
                errw  = 0;
            end
        end
    end

    // APB slave responder and APB-side checker
    initial begin : apb_slave
        bit          act;
        int          acc;
        apb_exp_t    cur;
        logic [NS-1:0] onehot;
        act = 1'b0;  acc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn || mon_off) begin
                pready  = '0;
                pslverr = '0;
                act     = 1'b0;
                continue;
            end
            pready  = NS'($urandom);
            pslverr = NS'($urandom);
            for (int s = 0; s < NS; s++) prdata[s*32 +: 32] = $urandom;
            if (act && !(psel != '0 && penable)) begin
                check("access_len", 32'(acc), cur.to ? 32'(TMO) : 32'(cur.k + 1));
                act = 1'b0;
            end
            if (psel != '0 && !penable) begin
                if (apb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL apb_unexpected: psel 0x%02h with empty queue at %0t", psel, $time);
                end else begin
                    cur    = apb_q.pop_front();
                    act    = 1'b1;
                    acc    = 0;
                    onehot = '0;
                    onehot[cur.slot] = 1'b1;
                    check("setup_psel", 32'(psel), 32'(onehot));
                    check("setup_paddr", paddr, cur.addr);
                    check("setup_pwrite", 32'(pwrite), 32'(cur.wr));
                    check("setup_pstrb", 32'(pstrb), 32'(cur.strb));
                    if (cur.wr) check("setup_pwdata", pwdata, cur.wdata);
                    pready[cur.slot] = 1'b0;
                end
            end else if (act && penable) begin
                acc++;
                check("access_psel", 32'(psel), 32'(onehot));
                check("access_paddr", paddr, cur.addr);
                check("access_pstrb", 32'(pstrb), 32'(cur.strb));
                if (cur.wr) check("access_pwdata", pwdata, cur.wdata);
                if (!cur.to && acc == cur.k + 1) begin
                    pready[cur.slot]          = 1'b1;
                    pslverr[cur.slot]         = cur.err;
                    prdata[cur.slot*32 +: 32] = cur.rdata;
                end else begin
                    pready[cur.slot] = 1'b0;
                end
            end else if (psel != '0 || penable) begin
                vectors++;
                miscompares++;
                $display("FAIL apb_stray: psel 0x%02h penable %0d at %0t", psel, penable, $time);
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a;
        int          guard;
        repeat (3) @(negedge clk);
        #2;
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_pstrb_pwrite", {27'd0, pstrb, pwrite}, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        issue(32'h4001_2004, 1'b0, 2, 32'h0, 0, 1'b0, 1'b0, 32'hA5A5_1234);
        idle(2);
        issue(32'h4001_3003, 1'b1, 0, 32'hDE00_0000, 3, 1'b0, 1'b0, 32'h0);
        idle(2);
        issue(32'h4001_7010, 1'b1, 2, 32'h1234_5678, 1, 1'b1, 1'b0, 32'h0);
        idle(2);
        issue(32'h4001_8000, 1'b0, 2, 32'h0, 0, 1'b0, 1'b0, 32'h0);
        idle(2);
        issue(32'h4001_5000, 1'b0, 2, 32'h0, 1000, 1'b0, 1'b1, 32'h0);
        idle(2);
        issue(32'h4001_0000, 1'b0, 2, 32'h0, 0, 1'b0, 1'b0, 32'h0BAD_F00D);
        issue(32'h4001_1008, 1'b1, 2, 32'hCAFE_0001, 0, 1'b0, 1'b0, 32'h0);
        idle(3);
        issue(32'h4000_FFFC, 1'b0, 2, 32'h0, 0, 1'b0, 1'b0, 32'h0);
        issue(32'h4001_4002, 1'b1, 1, 32'h5566_7788, 2, 1'b0, 1'b0, 32'h0);
        idle(2);

        for (int n = 0; n < 200; n++) begin
            int r;
            int sz;
            bit to;
            bit err;
            r   = int'($urandom % 100);
            sz  = int'($urandom % 3);
            a   = BASE + 32'($urandom % NS) * 32'd4096 + 32'($urandom % 1024) * 32'd4;
            if (sz == 0) a = a + 32'($urandom % 4);
            else if (sz == 1) a = a + 32'($urandom % 2) * 32'd2;
            if (r < 8) a = BASE + 32'(NS + int'($urandom % 8)) * 32'd4096 + 32'($urandom % 1024) * 32'd4;
            else if (r < 10) a = BASE - 32'd4 * (32'd1 + 32'($urandom % 64));
            to  = (r >= 10 && r < 14);
            err = ($urandom % 100) < 15;
            issue(a, 1'($urandom), sz, $urandom, int'($urandom % 4), err, to, $urandom);
            if ($urandom % 2 == 0) idle(int'($urandom % 4));
        end
        idle(40);
        check("ahb_q_drained", 32'(ahb_q.size()), 32'd0);
        check("apb_q_drained", 32'(apb_q.size()), 32'd0);

        // Asynchronous reset while a transfer sits in ACCESS
        mon_off = 1'b1;
        @(negedge clk);
        hsel = 1'b1;  haddr = 32'h4001_5000;  htrans = 2'b10;  hwrite = 1'b0;  hsize = 3'd2;
        @(negedge clk);
        hsel = 1'b0;  htrans = 2'b00;
        guard = 0;
        while (!penable && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("pre_reset_penable", 32'(penable), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_psel", 32'(psel), 32'd0);
        check("arst_penable", 32'(penable), 32'd0);
        check("arst_hreadyout", 32'(hreadyout), 32'd1);
        check("arst_hresp", 32'(hresp), 32'd0);
        check("arst_paddr", paddr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("post_reset_psel", 32'(psel), 32'd0);
        check("post_reset_hreadyout", 32'(hreadyout), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
